// File: rtl/cc_speed_pkg.sv
// Shared types and constants for the player-car speed scheduler.
// Holds the FSM encoding, the speed-level range and saturating level helpers.
package cc_speed_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_CRASH = 2'd3
    } state_t;

    localparam int LEVEL_MAX   = 7;
    localparam int LEVEL_WIDTH = 3;

    function automatic logic [LEVEL_WIDTH-1:0] lvl_inc(input logic [LEVEL_WIDTH-1:0] l);
        return (l == LEVEL_WIDTH'(LEVEL_MAX)) ? l : l + 1'b1;
    endfunction

    function automatic logic [LEVEL_WIDTH-1:0] lvl_dec(input logic [LEVEL_WIDTH-1:0] l);
        return (l == '0) ? l : l - 1'b1;
    endfunction

endpackage

// File: rtl/cc_speed_prescaler.sv
// Speed prescaler: counts up to a level-dependent limit and emits a registered
// one-cycle tick when the count has reached or passed that limit.
module cc_speed_prescaler
    import cc_speed_pkg::*;
#(
    parameter int DATAWIDTH = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   clr,
    input  logic [LEVEL_WIDTH-1:0] level,
    output logic                   tick
);

    logic [DATAWIDTH-1:0] count;
    logic [DATAWIDTH-1:0] limit;
    logic                 hit;

    // Each level halves the period; >= lets a raised level fire immediately
    // when the running count already exceeds the new, smaller limit.
    assign limit = {DATAWIDTH{1'b1}} >> (level - 1'b1);
    assign hit   = count >= limit;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (en) begin
            tick  <= hit;
            count <= hit ? '0 : count + 1'b1;
        end else begin
            tick  <= 1'b0;
        end
    end

endmodule

// File: rtl/cc_speed_scheduler.sv
// Player-car speed controller: control-strobe prescaler, level register and
// IDLE/RUN/PAUSE/CRASH sequencing around the speed prescaler that issues ticks.
module cc_speed_scheduler
    import cc_speed_pkg::*;
#(
    parameter int SPEEDSCHEDULER_DATAWIDTH    = 23,
    parameter int SPEEDSCHEDULER_CTRLWIDTH    = 20,
    parameter int SPEEDSCHEDULER_COASTDIV     = 4,
    parameter int SPEEDSCHEDULER_CRASHSTROBES = 8
) (
    input  logic       CC_SPEEDSCHEDULER_CLOCK_50,
    input  logic       CC_SPEEDSCHEDULER_RESET_InHigh,
    input  logic       CC_SPEEDSCHEDULER_start_InHigh,
    input  logic       CC_SPEEDSCHEDULER_pause_InHigh,
    input  logic       CC_SPEEDSCHEDULER_accel_InHigh,
    input  logic       CC_SPEEDSCHEDULER_brake_InHigh,
    input  logic       CC_SPEEDSCHEDULER_crash_InHigh,
    output logic       CC_SPEEDSCHEDULER_tick_OutHigh,
    output logic [2:0] CC_SPEEDSCHEDULER_level_OutBUS,
    output logic [1:0] CC_SPEEDSCHEDULER_state_OutBUS
);

    localparam int COAST_W = (SPEEDSCHEDULER_COASTDIV > 1) ? $clog2(SPEEDSCHEDULER_COASTDIV) : 1;
    localparam int CRASH_W = (SPEEDSCHEDULER_CRASHSTROBES > 1) ? $clog2(SPEEDSCHEDULER_CRASHSTROBES) : 1;
    localparam logic [COAST_W-1:0] COAST_LAST = COAST_W'(SPEEDSCHEDULER_COASTDIV - 1);
    localparam logic [CRASH_W-1:0] CRASH_LAST = CRASH_W'(SPEEDSCHEDULER_CRASHSTROBES - 1);

    logic clk, rst;
    logic start, pause, accel, brake, crash;

    assign clk   = CC_SPEEDSCHEDULER_CLOCK_50;
    assign rst   = CC_SPEEDSCHEDULER_RESET_InHigh;
    assign start = CC_SPEEDSCHEDULER_start_InHigh;
    assign pause = CC_SPEEDSCHEDULER_pause_InHigh;
    assign accel = CC_SPEEDSCHEDULER_accel_InHigh;
    assign brake = CC_SPEEDSCHEDULER_brake_InHigh;
    assign crash = CC_SPEEDSCHEDULER_crash_InHigh;

    state_t                              state, state_nxt;
    logic [LEVEL_WIDTH-1:0]              level, level_nxt;
    logic [SPEEDSCHEDULER_CTRLWIDTH-1:0] ctrl, ctrl_nxt;
    logic [COAST_W-1:0]                  coast, coast_nxt;
    logic [CRASH_W-1:0]                  crash_cnt, crash_nxt;
    logic                                ctrlstrobe;
    logic                                pre_en, pre_clr;

    assign ctrlstrobe = &ctrl;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            level     <= '0;
            ctrl      <= '0;
            coast     <= '0;
            crash_cnt <= '0;
        end else begin
            state     <= state_nxt;
            level     <= level_nxt;
            ctrl      <= ctrl_nxt;
            coast     <= coast_nxt;
            crash_cnt <= crash_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        level_nxt = level;
        ctrl_nxt  = ctrl;
        coast_nxt = coast;
        crash_nxt = crash_cnt;
        pre_en    = 1'b0;
        pre_clr   = 1'b0;
        case (state)
            ST_IDLE: begin
                pre_clr   = 1'b1;
                level_nxt = '0;
                ctrl_nxt  = '0;
                coast_nxt = '0;
                crash_nxt = '0;
                if (start) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (crash) begin
                    state_nxt = ST_CRASH;
                    level_nxt = '0;
                    coast_nxt = '0;
                    crash_nxt = '0;
                    ctrl_nxt  = ctrl + 1'b1;
                    pre_clr   = 1'b1;
                end else if (pause) begin
                    // Pause freezes everything from the cycle it is taken.
                    state_nxt = ST_PAUSE;
                end else begin
                    ctrl_nxt = ctrl + 1'b1;
                    pre_en   = (level != '0);
                    pre_clr  = (level == '0);
                    if (accel || brake) coast_nxt = '0;
                    if (ctrlstrobe) begin
                        if (brake) begin
                            level_nxt = lvl_dec(level);
                        end else if (accel) begin
                            level_nxt = lvl_inc(level);
                        end else if (coast == COAST_LAST) begin
                            coast_nxt = '0;
                            level_nxt = lvl_dec(level);
                        end else begin
                            coast_nxt = coast + 1'b1;
                        end
                    end
                end
            end
            ST_PAUSE: begin
                if (pause) state_nxt = ST_RUN;
            end
            ST_CRASH: begin
                ctrl_nxt = ctrl + 1'b1;
                pre_clr  = 1'b1;
                if (crash) begin
                    crash_nxt = '0;
                end else if (ctrlstrobe) begin
                    if (crash_cnt == CRASH_LAST) begin
                        state_nxt = ST_RUN;
                        level_nxt = '0;
                        crash_nxt = '0;
                    end else begin
                        crash_nxt = crash_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    cc_speed_prescaler #(
        .DATAWIDTH(SPEEDSCHEDULER_DATAWIDTH)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (pre_en),
        .clr  (pre_clr),
        .level(level),
        .tick (CC_SPEEDSCHEDULER_tick_OutHigh)
    );

    assign CC_SPEEDSCHEDULER_level_OutBUS = level;
    assign CC_SPEEDSCHEDULER_state_OutBUS = state;

endmodule

// File: tb/tb_cc_speed_scheduler.sv
// Scoreboard bench for cc_speed_scheduler: stimulus queues expected tick cycles
// and state/level snapshots; a negedge monitor pops and compares them.
module tb_cc_speed_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, pause = 1'b0, accel = 1'b0, brake = 1'b0, crash = 1'b0;
    logic       tick;
    logic [2:0] level;
    logic [1:0] state;

    int cyc    = 0;
    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int         c;
        logic [1:0] st;
        logic [2:0] lv;
    } exp_t;

    exp_t cq[$];
    int   tq[$];

    cc_speed_scheduler #(
        .SPEEDSCHEDULER_DATAWIDTH   (7),
        .SPEEDSCHEDULER_CTRLWIDTH   (4),
        .SPEEDSCHEDULER_COASTDIV    (2),
        .SPEEDSCHEDULER_CRASHSTROBES(3)
    ) dut (
        .CC_SPEEDSCHEDULER_CLOCK_50    (clk),
        .CC_SPEEDSCHEDULER_RESET_InHigh(rst),
        .CC_SPEEDSCHEDULER_start_InHigh(start),
        .CC_SPEEDSCHEDULER_pause_InHigh(pause),
        .CC_SPEEDSCHEDULER_accel_InHigh(accel),
        .CC_SPEEDSCHEDULER_brake_InHigh(brake),
        .CC_SPEEDSCHEDULER_crash_InHigh(crash),
        .CC_SPEEDSCHEDULER_tick_OutHigh(tick),
        .CC_SPEEDSCHEDULER_level_OutBUS(level),
        .CC_SPEEDSCHEDULER_state_OutBUS(state)
    );

    always #5 clk = ~clk;

    // cyc at a negedge is the index of the posedge whose results are visible.
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tq.size() > 0 && tq[0] < cyc) begin
            n_chk++;
            n_fail++;
            $display("FAIL tick_missing: no tick seen, required at cycle %0d", tq[0]);
            void'(tq.pop_front());
        end
        if (tick === 1'b1) begin
            n_chk++;
            if (tq.size() > 0 && tq[0] == cyc) begin
                void'(tq.pop_front());
            end else begin
                n_fail++;
                $display("FAIL tick_time: tick at cycle %0d, required next tick at %0d",
                         cyc, (tq.size() > 0) ? tq[0] : -1);
            end
        end
        for (int i = cq.size() - 1; i >= 0; i--) begin
            if (cq[i].c <= cyc) begin
                n_chk++;
                if (cq[i].c != cyc || state !== cq[i].st || level !== cq[i].lv) begin
                    n_fail++;
                    $display("FAIL state_level@%0d: state=%0d level=%0d, required state=%0d level=%0d",
                             cq[i].c, state, level, cq[i].st, cq[i].lv);
                end
                cq.delete(i);
            end
        end
    end

    task automatic exp_sl(input int c, input logic [1:0] st, input logic [2:0] lv);
        exp_t e;
        e.c  = c;
        e.st = st;
        e.lv = lv;
        cq.push_back(e);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        {start, pause, accel, brake, crash} = '0;
        exp_sl(cyc + 1, 2'd0, 3'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Returns S, the posedge that samples start; caller resumes at negedge S.
    task automatic start_run(output int s);
        @(negedge clk);
        start = 1'b1;
        s = cyc + 1;
        exp_sl(s, 2'd1, 3'd0);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int s;
        int k;

        // Idle: inputs other than start have no effect.
        do_reset();
        k = cyc;
        exp_sl(k + 20, 2'd0, 3'd0);
        accel = 1'b1; crash = 1'b1; pause = 1'b1;
        @(negedge clk);
        crash = 1'b0; pause = 1'b0;
        wait_until(k + 20);
        accel = 1'b0;

        // Ramp to level 3, hold it with one mid-strobe accel blip, then coast down.
        start_run(s);
        accel = 1'b1;
        exp_sl(s + 16, 2'd1, 3'd1);
        exp_sl(s + 32, 2'd1, 3'd2);
        exp_sl(s + 48, 2'd1, 3'd3);
        exp_sl(s + 95, 2'd1, 3'd3);
        exp_sl(s + 96, 2'd1, 3'd2);
        exp_sl(s + 128, 2'd1, 3'd1);
        exp_sl(s + 160, 2'd1, 3'd0);
        exp_sl(s + 200, 2'd1, 3'd0);
        tq.push_back(s + 49);
        tq.push_back(s + 81);
        wait_until(s + 48);  accel = 1'b0;
        wait_until(s + 70);  accel = 1'b1;
        wait_until(s + 71);  accel = 1'b0;
        wait_until(s + 200);

        // Accel and brake together: brake wins.
        do_reset();
        start_run(s);
        accel = 1'b1;
        exp_sl(s + 32, 2'd1, 3'd2);
        exp_sl(s + 48, 2'd1, 3'd1);
        exp_sl(s + 80, 2'd1, 3'd0);
        wait_until(s + 32);  brake = 1'b1;
        wait_until(s + 48);  accel = 1'b0; brake = 1'b0;
        wait_until(s + 85);

        // Pause at level 2 for 100 cycles; crash ignored; count resumes where it stopped.
        do_reset();
        start_run(s);
        accel = 1'b1;
        exp_sl(s + 32, 2'd1, 3'd2);
        exp_sl(s + 41, 2'd2, 3'd2);
        exp_sl(s + 91, 2'd2, 3'd2);
        exp_sl(s + 100, 2'd2, 3'd2);
        exp_sl(s + 141, 2'd1, 3'd2);
        exp_sl(s + 180, 2'd1, 3'd2);
        exp_sl(s + 181, 2'd1, 3'd1);
        exp_sl(s + 213, 2'd1, 3'd0);
        tq.push_back(s + 181);
        wait_until(s + 32);  accel = 1'b0;
        wait_until(s + 40);  pause = 1'b1;
        wait_until(s + 41);  pause = 1'b0;
        wait_until(s + 89);  crash = 1'b1;
        wait_until(s + 90);  crash = 1'b0;
        wait_until(s + 140); pause = 1'b1;
        wait_until(s + 141); pause = 1'b0;
        wait_until(s + 155); accel = 1'b1;
        wait_until(s + 156); accel = 1'b0;
        wait_until(s + 220);

        // Crash at level 5, recovery on third strobe, then crash+pause and reset mid-crash.
        do_reset();
        start_run(s);
        accel = 1'b1;
        exp_sl(s + 80, 2'd1, 3'd5);
        exp_sl(s + 84, 2'd1, 3'd5);
        exp_sl(s + 85, 2'd3, 3'd0);
        exp_sl(s + 120, 2'd3, 3'd0);
        exp_sl(s + 127, 2'd3, 3'd0);
        exp_sl(s + 128, 2'd1, 3'd0);
        exp_sl(s + 136, 2'd3, 3'd0);
        exp_sl(s + 139, 2'd3, 3'd0);
        exp_sl(s + 141, 2'd0, 3'd0);
        exp_sl(s + 150, 2'd0, 3'd0);
        tq.push_back(s + 49);
        tq.push_back(s + 65);
        tq.push_back(s + 81);
        wait_until(s + 80);  accel = 1'b0;
        wait_until(s + 84);  crash = 1'b1;
        wait_until(s + 85);  crash = 1'b0;
        wait_until(s + 90);  accel = 1'b1;
        wait_until(s + 125); accel = 1'b0;
        wait_until(s + 135); crash = 1'b1; pause = 1'b1;
        wait_until(s + 136); crash = 1'b0; pause = 1'b0;
        wait_until(s + 138); start = 1'b1;
        wait_until(s + 139); start = 1'b0;
        wait_until(s + 140); rst = 1'b1;
        wait_until(s + 141); rst = 1'b0;
        wait_until(s + 155);

        foreach (tq[i]) begin
            n_chk++;
            n_fail++;
            $display("FAIL tick_leftover: no tick seen, required at cycle %0d", tq[i]);
        end
        foreach (cq[i]) begin
            n_chk++;
            n_fail++;
            $display("FAIL check_leftover: check at cycle %0d never evaluated, required state=%0d level=%0d",
                     cq[i].c, cq[i].st, cq[i].lv);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cc_speed_scheduler.md
Name: cc_speed_scheduler

Overview:
- Speed controller for the player car.
- Owns the speed prescaler counter and compares it against a terminal value chosen by the current speed level. Each match produces a one-cycle game-advance tick.
- Sequences acceleration, braking, coasting, pause and crash recovery with a small FSM.
- Sits between the button/collision logic and the road-scroll and score blocks, which consume the tick.

Parameters:
- SPEEDSCHEDULER_DATAWIDTH, 23, width of the speed prescaler; must be >= 7.
- SPEEDSCHEDULER_CTRLWIDTH, 20, width of the control-strobe prescaler; strobe period is 2^CTRLWIDTH cycles.
- SPEEDSCHEDULER_COASTDIV, 4, control strobes per coast decrement when neither pedal is held.
- SPEEDSCHEDULER_CRASHSTROBES, 8, control strobes spent in CRASH before returning to RUN.

Ports:
- CC_SPEEDSCHEDULER_CLOCK_50  in  1  system clock.
- CC_SPEEDSCHEDULER_RESET_InHigh  in  1  reset; synchronous, active-high.
- CC_SPEEDSCHEDULER_start_InHigh  in  1  one-cycle start pulse.
- CC_SPEEDSCHEDULER_pause_InHigh  in  1  one-cycle pause-toggle pulse.
- CC_SPEEDSCHEDULER_accel_InHigh  in  1  accelerate pedal, level-sensitive.
- CC_SPEEDSCHEDULER_brake_InHigh  in  1  brake pedal, level-sensitive.
- CC_SPEEDSCHEDULER_crash_InHigh  in  1  one-cycle collision pulse.
- CC_SPEEDSCHEDULER_tick_OutHigh  out  1  one-cycle advance tick.
- CC_SPEEDSCHEDULER_level_OutBUS  out  3  current speed level, 0 to 7.
- CC_SPEEDSCHEDULER_state_OutBUS  out  2  FSM state: IDLE=0, RUN=1, PAUSE=2, CRASH=3.

Behaviour:
- Reset (synchronous, active-high, wins over every other input):
  - state IDLE, level 0, tick 0.
  - speed counter, control counter, coast counter and crash counter all 0.
- IDLE:
  - Counters held at 0.
  - On start: go to RUN next cycle; speed and control counters cleared.
  - pause, accel, brake and crash are ignored.
- RUN:
  - Control counter increments every cycle. When it reaches all-ones it raises ctrlstrobe for one cycle and wraps to 0.
  - On ctrlstrobe the level updates with this priority:
    - brake: level-1, saturating at 0.
    - else accel: level+1, saturating at 7.
    - else coast counter increments; when it reaches COASTDIV-1 it clears and level-1, saturating at 0.
  - accel or brake active clears the coast counter.
  - Speed counter runs only when level>0.
    - limit = (all-ones of DATAWIDTH) >> (level-1).
    - When count >= limit: tick=1 that cycle and the counter clears. Otherwise count+1.
    - Tick period is limit+1 cycles: level 1 = 2^DATAWIDTH, level 7 = 2^(DATAWIDTH-6).
    - The >= compare makes a level increase mid-count fire on the next cycle, not after a wrap.
  - Level 0: speed counter held at 0, no ticks.
- PAUSE:
  - Entered from RUN on a pause pulse; left back to RUN on the next pause pulse.
  - All counters frozen, level held, tick 0.
  - A crash during PAUSE is ignored.
- CRASH:
  - Entered from RUN on a crash pulse. In the same cycle: level forced to 0, speed counter cleared, crash counter cleared.
  - Control counter keeps running. Each ctrlstrobe increments the crash counter.
  - When the crash counter reaches CRASHSTROBES-1 on a strobe, go to RUN with level 0.
  - accel, brake, pause and start are ignored in CRASH.
  - A further crash pulse restarts the crash counter.
- Simultaneous events in RUN:
  - crash beats pause.
  - pause beats level update and tick: no tick is issued in the cycle pause is taken.
  - A tick and ctrlstrobe in the same cycle: the tick uses the old level; the new level applies from the next cycle.
- start in RUN, PAUSE or CRASH: no effect. Only reset returns the block to IDLE.
- Registered outputs; tick latency is one cycle after the counter reaches limit.

Decomposition:
- Package cc_speed_pkg holds:
  - the state encoding (IDLE, RUN, PAUSE, CRASH);
  - LEVEL_MAX=7 and LEVEL_WIDTH=3.
- One natural sub-module: cc_speed_prescaler, holding the speed counter, the limit shift and the >= compare, with enable, clear and tick.
- The control counter, FSM and level register stay in the top module.

Test Plan (bench uses DATAWIDTH=7, CTRLWIDTH=4, COASTDIV=2, CRASHSTROBES=3):
- Reset then idle 20 cycles -> state 0, level 0, no ticks. Assert start -> state 1 next cycle.
- From RUN, hold accel 48 cycles -> level goes 1, 2, 3 at strobes 16, 32 and 48 cycles after entering RUN. At level 3 (limit 31) ticks are spaced exactly 32 cycles apart.
- Level 3, release both pedals -> level decrements every 32 cycles (2 strobes) down to 0, then ticks stop. Hold accel and brake together at level 2 -> level 1 at the next strobe.
- Level 2, pause pulse -> state 2, speed counter frozen, no ticks for 100 cycles. Second pause -> state 1 and ticking resumes with the remaining count, not from 0.
- Level 5, crash pulse -> state 3 and level 0 in the same cycle. RUN resumes at the third strobe (48 cycles max). accel during CRASH does not change level.
- Crash and pause pulses in the same cycle -> state 3. Reset asserted mid-CRASH -> state 0, level 0 next cycle.
